// File: rtl/ws2812_frame_buffer.sv
// ws2812_frame_buffer
//   Double-buffered pixel store for a ws2812 strip driver. The driver fetches
//   pixels from the front bank through address_i and gets registered RGB one
//   cycle later. The host writes 24-bit RGB words into the back bank. A swap
//   request exchanges the banks only at a frame boundary, so a half-updated
//   frame is never shown.
//
// Ports
//   clk_i          single clock, shared with the strip driver
//   rst_i          asynchronous, active-high reset
//   address_i      pixel fetch address from the driver
//   r_o/g_o/b_o    registered pixel data for the driver (0 when out of range)
//   wr_addr_i      host pixel index
//   wr_data_i      host pixel {R, G, B}
//   wr_en_i        host write strobe, one word per cycle
//   swap_req_i     single-cycle request to present the back bank
//   swap_pending_o high while a swap waits for the frame boundary
//   front_bank_o   bank currently read by the driver
//   frame_done_o   one-cycle pulse after every frame-end event
module ws2812_frame_buffer #(
    parameter int LED_COUNT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [8:0]  address_i,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o,
    input  logic [8:0]  wr_addr_i,
    input  logic [23:0] wr_data_i,
    input  logic        wr_en_i,
    input  logic        swap_req_i,
    output logic        swap_pending_o,
    output logic        front_bank_o,
    output logic        frame_done_o
);

    localparam int         AW        = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [9:0] COUNT     = 10'(LED_COUNT);
    localparam logic [8:0] LAST_ADDR = 9'(LED_COUNT - 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state, next_state;

    logic [23:0]   mem [2][LED_COUNT];
    logic [8:0]    addr_q;
    logic          rd_in_range;
    logic          wr_in_range;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          frame_end;
    logic          do_swap;

    assign rd_in_range = ({1'b0, address_i} < COUNT);
    assign wr_in_range = ({1'b0, wr_addr_i} < COUNT);
    assign rd_idx      = address_i[AW-1:0];
    assign wr_idx      = wr_addr_i[AW-1:0];

    // The driver has just left its last pixel: this is the only point where
    // the front bank may change without tearing the frame on the strip.
    assign frame_end = (addr_q == LAST_ADDR) && (address_i != LAST_ADDR);

    // Host writes always target the bank the driver is not reading. The bank
    // select is the registered front_bank_o, i.e. the value before any swap
    // taking effect on this same edge.
    // NOTE: the pixel RAM has no reset so it can map onto block RAM; its
    // contents deliberately survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_in_range) begin
            mem[~front_bank_o][wr_idx] <= wr_data_i;
        end
    end

    // NOTE: every register here is assigned with <= so all of them sample
    // the pre-edge values; the read below therefore still sees the old
    // front bank on the same edge that front_bank_o toggles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {r_o, g_o, b_o} <= 24'd0;
            addr_q          <= 9'd0;
            state           <= IDLE;
            front_bank_o    <= 1'b0;
            frame_done_o    <= 1'b0;
        end else begin
            if (rd_in_range) begin
                {r_o, g_o, b_o} <= mem[front_bank_o][rd_idx];
            end else begin
                {r_o, g_o, b_o} <= 24'd0;
            end
            addr_q       <= address_i;
            state        <= next_state;
            frame_done_o <= frame_end;
            if (do_swap) begin
                front_bank_o <= ~front_bank_o;
            end
        end
    end

    // A request that coincides with a frame end swaps at once and never
    // enters PENDING; requests while PENDING are not queued.
    // NOTE: outputs of this block get defaults first so no path leaves them
    // unassigned, which would infer latches.
    always_comb begin
        next_state = state;
        do_swap    = 1'b0;
        unique case (state)
            IDLE: begin
                if (swap_req_i) begin
                    if (frame_end) begin
                        do_swap = 1'b1;
                    end else begin
                        next_state = PENDING;
                    end
                end
            end
            PENDING: begin
                if (frame_end) begin
                    do_swap    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign swap_pending_o = (state == PENDING);

endmodule

// File: doc/ws2812_frame_buffer.md
# ws2812_frame_buffer

Double-buffered pixel store that sits directly upstream of the `ws2812` strip driver and answers its `address_o` pixel fetches with registered `r`/`g`/`b` data. A host side writes 24-bit RGB words into the back bank while the driver reads the front bank. A swap request exchanges the two banks only at a frame boundary, so the strip never shows a half-updated frame.

## Interface
- `LED_COUNT`, default 8: pixels per frame, 1..512.
- `rst_i`  in  1  asynchronous, active-high reset.
- `clk_i`  in  1  single clock, shared with `ws2812`.
- `address_i`  in  9  pixel address from the driver's `address_o`.
- `r_o`, `g_o`, `b_o`  out  8 each  pixel data to the driver's `r_i`/`g_i`/`b_i`.
- `wr_addr_i`  in  9  host pixel index.
- `wr_data_i`  in  24  host pixel: R = [23:16], G = [15:8], B = [7:0].
- `wr_en_i`  in  1  host write strobe, one word per cycle.
- `swap_req_i`  in  1  single-cycle request to present the back bank at the next frame boundary.
- `swap_pending_o`  out  1  high from request acceptance until the swap executes.
- `front_bank_o`  out  1  index of the bank currently read by the driver.
- `frame_done_o`  out  1  one-cycle pulse on every frame-end event.

## Operation
- Storage: 2 × `LED_COUNT` × 24-bit RAM. Entry `{bank, index}`. Contents are not reset.
- Read path:
  - Every cycle, `{r_o, g_o, b_o}` <= RAM[`front_bank_o`][`address_i`].
  - If `address_i` >= `LED_COUNT`, the registered output is 0.
- Write path:
  - When `wr_en_i` is high and `wr_addr_i` < `LED_COUNT`, write RAM[~`front_bank_o`][`wr_addr_i`] <= `wr_data_i`.
  - Out-of-range writes are dropped silently.
  - Bank selection uses the `front_bank_o` value from before any swap in the same cycle.
- Frame-end detect:
  - Register `addr_q` <= `address_i` each cycle; reset value 0.
  - Frame-end event when `addr_q` == `LED_COUNT`-1 and `address_i` != `LED_COUNT`-1.
  - For `LED_COUNT` = 1 this means `addr_q` == 0 and `address_i` != 0.
- Swap FSM:
  - IDLE: `swap_req_i` moves to PENDING. If a frame-end event occurs in the same cycle, swap immediately and stay in IDLE.
  - PENDING: on a frame-end event, toggle `front_bank_o` and return to IDLE. Further `swap_req_i` pulses are ignored (no queuing).
  - `swap_pending_o` = (state == PENDING).
- `frame_done_o` pulses on every frame-end event, whether or not a swap occurs.
- Writes are legal in any state. Writes landing while PENDING become visible after the swap.

## Timing
- Reset values:
  - `r_o`, `g_o`, `b_o` = 0.
  - `front_bank_o` = 0.
  - `swap_pending_o` = 0.
  - `frame_done_o` = 0.
  - `addr_q` = 0; FSM in IDLE.
- Read latency is 1 cycle: data for `address_i` sampled at edge N is valid after edge N. This matches the driver's fetch timing.
- Swap boundary:
  - The read sampled on the frame-end cycle still uses the old front bank.
  - `front_bank_o` toggles at that edge. The first read from the new bank is on the following cycle.
- Host visibility:
  - A write at edge N is visible to a back-bank readback only after a swap.
  - No write-through to the front bank.
- `swap_pending_o` rises one edge after `swap_req_i` and falls at the swap edge.
- Reset mid-frame or mid-PENDING: all state returns to reset values immediately (async). RAM contents are retained. The pending request is lost.

## Test plan
- Swap at boundary:
  - Setup: reset; write bank 1 pixels i = 0..7 with {i, i+100, i+200}; pulse `swap_req_i`; drive `address_i` 0..7 then 8.
  - Required: `swap_pending_o` = 1 until the 7→8 transition; `front_bank_o` goes 0→1 there; `frame_done_o` pulses once.
  - Next pass 0..7: outputs {i, i+100, i+200}, 1-cycle latency.
- Mid-frame request:
  - Stimulus: assert `swap_req_i` while `address_i` = 3.
  - Required: `front_bank_o` does not change until `address_i` leaves 7. Reads at 4..7 still return old-bank data.
- Simultaneous request and frame end:
  - Stimulus: `swap_req_i` on the cycle `address_i` goes 7→0.
  - Required: swap at that edge; `swap_pending_o` never asserts.
- Out of range:
  - Stimulus: write `wr_addr_i` = 8, data 0xFFFFFF; read `address_i` = 9.
  - Required: RAM unchanged; outputs 0.
- Reset during PENDING:
  - Stimulus: assert `rst_i` while `swap_pending_o` = 1.
  - Required: `swap_pending_o` = 0, `front_bank_o` = 0, RGB outputs = 0 asynchronously.
  - After release: earlier bank-0 data still reads back.
- Repeated request:
  - Stimulus: two `swap_req_i` pulses within one frame.
  - Required: exactly one toggle of `front_bank_o` at the frame end.
